// File: rtl/alu_pkg.sv
// Shared op-codes and widths for the 3-bit registered ALU.
package alu_pkg;
  localparam int OPND_W = 3;
  localparam int RES_W  = 4;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;
endpackage

// File: rtl/alu_core.sv
// Combinational datapath: operands zero-extended to the result width, one op per select code.
module alu_core
  import alu_pkg::*;
(
  input  logic [1:0]        swSelect,
  input  logic [OPND_W-1:0] a,
  input  logic [OPND_W-1:0] b,
  output logic [RES_W-1:0]  result
);
  logic [RES_W-1:0] ax, bx;

  assign ax = {1'b0, a};
  assign bx = {1'b0, b};

  // SUB wraps mod 16, so the top bit doubles as the borrow flag.
  always_comb begin
    result = '0;
    case (swSelect)
      OP_ADD: result = ax + bx;
      OP_SUB: result = ax - bx;
      OP_AND: result = ax & bx;
      OP_OR:  result = ax | bx;
    endcase
  end
endmodule

// File: rtl/alu.sv
// Registered ALU top: combinational core feeding one output register with sync reset.
module alu
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        swSelect,
  input  logic [OPND_W-1:0] a,
  input  logic [OPND_W-1:0] b,
  output logic [RES_W-1:0]  q
);
  logic [RES_W-1:0] result;

  alu_core u_core (
    .swSelect (swSelect),
    .a        (a),
    .b        (b),
    .result   (result)
  );

  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= result;
  end
endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: driver queues expected q per edge, monitor checks after each edge.
module tb_alu;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] swSelect;
  logic [2:0] a, b;
  logic [3:0] q;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [3:0] exp;
    string      name;
  } exp_t;

  exp_t exp_q[$];

  alu dut (
    .clk      (clk),
    .rst      (rst),
    .swSelect (swSelect),
    .a        (a),
    .b        (b),
    .q        (q)
  );

  always #5 clk = ~clk;

  // Drive one vector on the falling edge; its result is due at the next rising edge.
  task automatic apply(input logic r, input logic [1:0] s, input logic [2:0] va,
                       input logic [2:0] vb, input logic [3:0] e, input string nm);
    exp_t it;
    @(negedge clk);
    rst = r; swSelect = s; a = va; b = vb;
    it.exp = e; it.name = nm;
    exp_q.push_back(it);
  endtask

  // Monitor: every edge with an outstanding expectation is checked 1 time unit later.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t it;
      it = exp_q.pop_front();
      compared++;
      if (q !== it.exp) begin
        mismatched++;
        $display("FAIL %s: q=%b expected %b", it.name, q, it.exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; swSelect = 2'b00; a = '0; b = '0;
    repeat (2) @(negedge clk);

    apply(1'b1, 2'b00, 3'd7, 3'd7, 4'b0000, "reset_priority");
    apply(1'b0, 2'b00, 3'd7, 3'd7, 4'b1110, "first_after_reset_7p7");

    apply(1'b0, 2'b00, 3'd3, 3'd4, 4'b0111, "add_3p4");
    apply(1'b0, 2'b00, 3'd0, 3'd0, 4'b0000, "add_0p0");

    apply(1'b0, 2'b01, 3'd5, 3'd2, 4'b0011, "sub_5m2");
    apply(1'b0, 2'b01, 3'd0, 3'd1, 4'b1111, "sub_0m1");
    apply(1'b0, 2'b01, 3'd0, 3'd7, 4'b1001, "sub_0m7");
    apply(1'b0, 2'b01, 3'd7, 3'd0, 4'b0111, "sub_7m0");
    apply(1'b0, 2'b01, 3'd4, 3'd4, 4'b0000, "sub_equal");

    apply(1'b0, 2'b10, 3'b110, 3'b011, 4'b0010, "and_110_011");
    apply(1'b0, 2'b11, 3'b110, 3'b011, 4'b0111, "or_110_011");
    apply(1'b0, 2'b10, 3'b111, 3'b111, 4'b0111, "and_all_ones");
    apply(1'b0, 2'b11, 3'b000, 3'b000, 4'b0000, "or_zero");

    apply(1'b0, 2'b00, 3'd6, 3'd3, 4'd9, "b2b_add");
    apply(1'b0, 2'b01, 3'd6, 3'd3, 4'd3, "b2b_sub");
    apply(1'b0, 2'b10, 3'd6, 3'd3, 4'd2, "b2b_and");
    apply(1'b0, 2'b11, 3'd6, 3'd3, 4'd7, "b2b_or");

    apply(1'b0, 2'b00, 3'd6, 3'd3, 4'd9, "mid_add");
    apply(1'b0, 2'b01, 3'd6, 3'd3, 4'd3, "mid_sub");
    apply(1'b1, 2'b10, 3'd6, 3'd3, 4'd0, "mid_reset");
    apply(1'b0, 2'b10, 3'd6, 3'd3, 4'd2, "mid_resume_and");
    apply(1'b0, 2'b11, 3'd6, 3'd3, 4'd7, "mid_resume_or");

    // Result must hold across the cycle even if inputs glitch after the edge.
    @(posedge clk); #2;
    swSelect = 2'b00; a = 3'd1; b = 3'd1;
    #2;
    swSelect = 2'b11; a = 3'd6; b = 3'd3;
    #1;
    compared++;
    if (q !== 4'd7) begin
      mismatched++;
      $display("FAIL hold_between_edges: q=%b expected %b", q, 4'd7);
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      mismatched++;
      $display("FAIL drain: %0d expectations never checked, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/alu.md
# alu

Registered 3-bit arithmetic/logic unit for the mini-project datapath. It takes two unsigned 3-bit operands from board switches and a 2-bit operation select. Each clock it produces a 4-bit result that drives the LED/display stage. Combinational compute feeds a single output register, so the result is stable for a full cycle.

## Interface
- No parameters; all widths fixed (operands 3 bits, result 4 bits, select 2 bits).
- Reset is synchronous and active-high: `rst` is sampled only on the rising edge of `clk`, and a high level clears the block.
- `clk`  in  1  single system clock, rising-edge active.
- `rst`  in  1  synchronous active-high reset.
- `swSelect`  in  2  operation select (encoding below).
- `a`  in  3  operand A, unsigned.
- `b`  in  3  operand B, unsigned.
- `q`  out  4  registered result.

## Operation
- `swSelect` 2'b00, ADD: q = {1'b0,a} + {1'b0,b}.
  - Full 4-bit sum; q[3] is the carry.
  - Range 0..14; no overflow possible.
- `swSelect` 2'b01, SUB: q = ({1'b0,a} - {1'b0,b}) mod 16.
  - 4-bit two's complement; q[3] = 1 exactly when b > a (borrow/negative).
  - Range -7..+7 in two's complement.
- `swSelect` 2'b10, AND: q = {1'b0, a & b}.
- `swSelect` 2'b11, OR: q = {1'b0, a | b}.
- All operands are treated as unsigned and zero-extended to 4 bits before the operation.
- No internal state other than the `q` register. No enable: every non-reset edge loads a new result.
- X/undefined select values cannot occur at the register input because the case covers all four codes. No default latch.

## Timing
- Latency: 1 cycle. `q` after rising edge N reflects `a`, `b` and `swSelect` sampled at edge N.
- Throughput: one operation per cycle. Operands and select may change every cycle.
- Reset: `rst` high at a rising edge forces q = 4'b0000 at that edge, regardless of inputs.
  - Reset has priority over any operation.
  - The first post-reset result appears at the first edge with `rst` low.
- Reset asserted mid-stream discards the in-flight operation; no result from that edge is ever presented.
- Between edges `q` holds. Input glitches between edges have no effect on `q`.
- Power-up before the first reset edge: `q` is undefined. The bench must not check `q` until after a reset edge.

## Structure
- Shared package `alu_pkg` holds:
  - op-code constants OP_ADD = 2'b00, OP_SUB = 2'b01, OP_AND = 2'b10, OP_OR = 2'b11;
  - width constants OPND_W = 3 and RES_W = 4.
- One sub-module, `alu_core`: purely combinational. Inputs are `swSelect`, `a` and `b`; output is the 4-bit `result`, driven by a full case on the op code.
- Top `alu` instantiates `alu_core` and adds the synchronous-reset output register.

## Test plan
- Reset: drive rst=1 with a=3'b111, b=3'b111, swSelect=00 for one edge -> q=4'b0000. Release rst; next edge -> q=4'b1110 (7+7).
- ADD: a=3, b=4, sel=00 -> q=4'b0111 one edge later. Then a=0, b=0 -> q=4'b0000.
- SUB: a=5, b=2, sel=01 -> q=4'b0011. Then a=0, b=1 -> q=4'b1111. Then a=0, b=7 -> q=4'b1001.
- Logic: a=3'b110, b=3'b011 -> sel=10 gives q=4'b0010; sel=11 gives q=4'b0111.
- Back-to-back: change sel every cycle 00,01,10,11 with a=6, b=3 -> q sequence 9, 3, 2, 7 on consecutive edges. No bubbles.
- Mid-stream reset: during the sequence above, assert rst for one edge -> q=0 at that edge. The following edge resumes with the current inputs.
